barrel_shift_pipe: RTL and testbench
====================================

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16: data width; a power of two and at least 2; any other value SHALL fail elaboration.
REQ-002 The block SHALL expose parameter DIST_WIDTH, default $clog2(WIDTH)+1: distance width; at least $clog2(WIDTH), else elaboration fails.
REQ-003 The block SHALL expose parameter STAGES, default 2: number of register stages, 1..DIST_WIDTH, else elaboration fails.
REQ-004 The block SHALL expose parameter USER_W, default 1: width of the sideband tag carried alongside each beat.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all registers on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit: input beat present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts the input beat this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: operand.
REQ-010 The block SHALL have port in_dist, input, DIST_WIDTH bits: shift or rotate distance.
REQ-011 The block SHALL have port in_mode, input, 2 bits: 0 ROR, 1 ROL, 2 SHR logical, 3 SHR arithmetic.
REQ-012 The block SHALL have port in_user, input, USER_W bits: sideband tag, passed through unchanged.
REQ-013 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-015 The block SHALL have port out_data, output, WIDTH bits: result.
REQ-016 The block SHALL have port out_user, output, USER_W bits: tag of the result beat.

Function
REQ-017 A beat SHALL transfer on either side only in a cycle where valid and ready are both high.
REQ-018 ROR SHALL produce in_data rotated toward the LSB by (in_dist mod WIDTH).
REQ-019 ROL SHALL produce in_data rotated toward the MSB by (in_dist mod WIDTH).
REQ-020 SHR logical SHALL zero-fill from the MSB; any distance of WIDTH or more SHALL give all zeros.
REQ-021 SHR arithmetic SHALL fill with in_data[WIDTH-1]; any distance of WIDTH or more SHALL give all bits equal to the sign bit.
REQ-022 Distance bits SHALL be consumed MSB-group first and split as evenly as possible across STAGES registered stages, with at least one distance bit per stage.
REQ-023 Latency from input transfer to out_valid SHALL be exactly STAGES cycles when out_ready is held high.
REQ-024 Throughput SHALL be one beat per cycle when out_ready is high.
REQ-025 Each stage SHALL hold a valid bit, data, residual distance, mode and user fields.
REQ-026 A global advance SHALL be asserted as (~out_valid | out_ready); all stages load together on advance and hold otherwise.
REQ-027 in_ready SHALL equal the global advance; there SHALL be no combinational path from in_valid to in_ready.
REQ-028 Bubbles SHALL NOT be collapsed; at most STAGES beats are in flight.
REQ-029 Results SHALL leave in acceptance order with their own tag, with no loss or duplication under any out_ready pattern.
REQ-030 While out_valid is high and out_ready is low, out_data and out_user SHALL be held stable.
REQ-031 in_data, in_dist, in_mode and in_user SHALL be ignored when in_valid is low.

Reset
REQ-032 Asserting rst SHALL immediately clear every stage valid bit, so out_valid is 0 without waiting for a clock edge.
REQ-033 While rst is asserted, in_ready SHALL be 0 and out_data and out_user SHALL be 0.
REQ-034 Beats in flight when rst asserts SHALL be discarded.
REQ-035 On the first clk edge after rst deasserts, in_ready SHALL be 1.

Structure
REQ-036 Package shift_pkg SHALL hold the mode enum shift_mode_t (ROR, ROL, SHR, ASR) and a function giving the distance bits per stage.
REQ-037 A sub-module shift_stage SHALL implement one stage: combinational shift over its distance-bit group, followed by the stage register.
REQ-038 barrel_shift_pipe SHALL instantiate shift_stage STAGES times and own the advance logic.

Verification
REQ-039 Rotate case (WIDTH=16, STAGES=2): ROR with in_data 0x8001, dist 1 -> out_data 0xC000 exactly 2 cycles after transfer; ROL with 0x8001, dist 4 -> 0x0018.
REQ-040 Distance wrap case: ROR with 0x0003, dist 17 -> 0x8001, identical to dist 1.
REQ-041 Saturating shift case: ASR with 0x8000, dist 20 -> 0xFFFF; SHR with the same operands -> 0x0000; ASR with 0x4000, dist 3 -> 0x0800.
REQ-042 Backpressure case: feed 4 back-to-back beats, tags 0..3, with out_ready low for 5 cycles. in_ready SHALL drop once 2 beats are held, out_data SHALL be stable while stalled, and after release tags SHALL leave 0,1,2,3 with correct data.
REQ-043 Reset case: assert rst asynchronously with 2 beats in flight -> out_valid SHALL be 0 before the next clk edge, and neither beat SHALL ever appear at the output.
REQ-044 Random regression: every combination of STAGES 1..DIST_WIDTH and every mode, with random out_ready, SHALL match a reference model over 10k beats.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shift modes and the distance-bit split across pipeline stages
package shift_pkg;

   typedef enum logic [1:0] {ROR = 2'd0, ROL = 2'd1, SHR = 2'd2, ASR = 2'd3} shift_mode_t;

   function automatic int stage_bits(input int dw, input int st, input int idx);
      return dw / st + ((idx < dw % st) ? 1 : 0);
   endfunction

   function automatic int stage_hi(input int dw, input int st, input int idx);
      int h;
      h = dw - 1;
      for (int j = 0; j < idx; j++) h -= stage_bits(dw, st, j);
      return h;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage: shift over distance bits [HI:LO], then the stage register
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int DIST_WIDTH = 5,
   parameter int USER_W     = 1,
   parameter int HI         = 4,
   parameter int LO         = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  adv,
   input  logic                  in_valid,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [DIST_WIDTH-1:0] in_dist,
   input  shift_mode_t           in_mode,
   input  logic [USER_W-1:0]     in_user,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [DIST_WIDTH-1:0] out_dist,
   output shift_mode_t           out_mode,
   output logic [USER_W-1:0]     out_user
);

   localparam int LOG = $clog2(WIDTH);
   localparam logic [LOG:0] WL = (LOG + 1)'(WIDTH);
   localparam logic [DIST_WIDTH-1:0] MASK =
      DIST_WIDTH'(((64'd1 << (HI + 1)) - 64'd1) & ~((64'd1 << LO) - 64'd1));

   logic [DIST_WIDTH-1:0] amt;
   logic                  big;
   logic [LOG-1:0]        r;
   logic [LOG:0]          nr;
   logic                  fill;
   logic [WIDTH-1:0]      res;

   // partial shift by this stage's weight; weights >= WIDTH saturate shifts and vanish in rotates
   always_comb begin
      amt  = in_dist & MASK;
      big  = (amt >> LOG) != '0;
      r    = amt[LOG-1:0];
      nr   = WL - {1'b0, r};
      fill = (in_mode == ASR) & in_data[WIDTH-1];
      res  = in_mode == ROR ? (in_data >> r) | (in_data << nr) :
             in_mode == ROL ? (in_data << r) | (in_data >> nr) :
             big            ? {WIDTH{fill}} :
                              (in_data >> r) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> r));
   end

   // stage register: loads on global advance, cleared immediately by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_dist  <= '0;
         out_mode  <= ROR;
         out_user  <= '0;
      end else if (adv) begin
         out_valid <= in_valid;
         out_data  <= res;
         out_dist  <= in_dist & ~MASK;
         out_mode  <= in_mode;
         out_user  <= in_user;
      end
   end

endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined rotate/shift unit with valid/ready flow control
module barrel_shift_pipe
   import shift_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int DIST_WIDTH = $clog2(WIDTH) + 1,
   parameter int STAGES     = 2,
   parameter int USER_W     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [DIST_WIDTH-1:0] in_dist,
   input  logic [1:0]            in_mode,
   input  logic [USER_W-1:0]     in_user,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [USER_W-1:0]     out_user
);

   if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("WIDTH must be a power of two, at least 2");
   end
   if (DIST_WIDTH < $clog2(WIDTH)) begin : g_bad_dist
      $error("DIST_WIDTH must be at least clog2(WIDTH)");
   end
   if (STAGES < 1 || STAGES > DIST_WIDTH) begin : g_bad_stages
      $error("STAGES must be within 1..DIST_WIDTH");
   end

   logic                             adv;
   logic [STAGES:0]                  v;
   logic [STAGES:0][WIDTH-1:0]       d;
   logic [STAGES:0][DIST_WIDTH-1:0]  s;
   shift_mode_t [STAGES:0]           m;
   logic [STAGES:0][USER_W-1:0]      u;
   logic                             unused_tail;

   assign v[0] = in_valid;
   assign d[0] = in_data;
   assign s[0] = in_dist;
   assign m[0] = shift_mode_t'(in_mode);
   assign u[0] = in_user;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      localparam int HI = stage_hi(DIST_WIDTH, STAGES, i);
      localparam int LO = HI - stage_bits(DIST_WIDTH, STAGES, i) + 1;
      shift_stage #(
         .WIDTH(WIDTH), .DIST_WIDTH(DIST_WIDTH), .USER_W(USER_W), .HI(HI), .LO(LO)
      ) u_stage (
         .clk(clk), .rst(rst), .adv(adv),
         .in_valid(v[i]), .in_data(d[i]), .in_dist(s[i]), .in_mode(m[i]), .in_user(u[i]),
         .out_valid(v[i+1]), .out_data(d[i+1]), .out_dist(s[i+1]), .out_mode(m[i+1]),
         .out_user(u[i+1])
      );
   end

   // the whole pipe moves as one; in_ready depends only on registered state, out_ready and rst
   assign adv         = ~v[STAGES] | out_ready;
   assign in_ready    = adv & ~rst;
   assign out_valid   = v[STAGES];
   assign out_data    = d[STAGES];
   assign out_user    = u[STAGES];
   assign unused_tail = ^{s[STAGES], m[STAGES]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed cases plus randomized regression for STAGES 1..5
module tb_barrel_shift_pipe;

   localparam int BEATS = 2500;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_r = 1'b1;
   logic        go = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [4:0]  in_dist = '0;
   logic [1:0]  in_mode = '0;
   logic [7:0]  in_user = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [7:0]  out_user;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   barrel_shift_pipe #(.WIDTH(16), .STAGES(2), .USER_W(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_dist(in_dist), .in_mode(in_mode), .in_user(in_user), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_user(out_user)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] dt, input logic [4:0] ds, input logic [1:0] md);
      logic [15:0] r;
      int k;
      k = int'(ds);
      for (int i = 0; i < 16; i++) begin
         case (md)
            2'd0:    r[i] = dt[(i + k) % 16];
            2'd1:    r[i] = dt[(i - (k % 16) + 16) % 16];
            2'd2:    r[i] = (i + k < 16) ? dt[(i + k) % 16] : 1'b0;
            default: r[i] = (i + k < 16) ? dt[(i + k) % 16] : dt[15];
         endcase
      end
      return r;
   endfunction

   task automatic xfer(input string tag, input logic [15:0] dt, input logic [4:0] ds,
                       input logic [1:0] md, input logic [7:0] ut, input logic [15:0] exp);
      @(negedge clk);
      in_valid = 1'b1; in_data = dt; in_dist = ds; in_mode = md; in_user = ut; out_ready = 1'b1;
      #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0; in_data = 16'($urandom);
      check({tag, "_early"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({tag, "_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(exp));
      check({tag, "_user"}, 32'(out_user), 32'(ut));
   endtask

   for (genvar g = 1; g <= 5; g++) begin : g_rnd
      logic        iv = 1'b0, ir, ov, ordy = 1'b0, fin = 1'b0;
      logic [15:0] id = '0, od;
      logic [4:0]  is = '0;
      logic [1:0]  im = '0;
      logic [7:0]  iu = '0, ou;

      barrel_shift_pipe #(.WIDTH(16), .STAGES(g), .USER_W(8)) u_rdut (
         .clk(clk), .rst(rst_r), .in_valid(iv), .in_ready(ir), .in_data(id), .in_dist(is),
         .in_mode(im), .in_user(iu), .out_valid(ov), .out_ready(ordy), .out_data(od),
         .out_user(ou)
      );

      initial begin
         logic [23:0] q[$];
         logic [23:0] held;
         logic        hold_v;
         int          n;
         int          cyc;
         n = 0; cyc = 0; hold_v = 1'b0; held = '0;
         wait (go);
         while ((n < BEATS || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            iv   = (n < BEATS) && ($urandom_range(3) != 0);
            id   = 16'($urandom);
            is   = 5'($urandom);
            im   = 2'($urandom);
            iu   = 8'($urandom);
            ordy = $urandom_range(3) != 0;
            #1;
            if (hold_v) check($sformatf("rnd%0d_hold", g), 32'({ou, od}), 32'(held));
            if (iv && ir) begin
               q.push_back({iu, model(id, is, im)});
               n++;
            end
            if (ov && ordy) begin
               if (q.size() == 0) check($sformatf("rnd%0d_extra", g), 32'(q.size()), 32'd1);
               else check($sformatf("rnd%0d_beat", g), 32'({ou, od}), 32'(q.pop_front()));
            end
            hold_v = ov && !ordy;
            held   = {ou, od};
         end
         iv = 1'b0;
         check($sformatf("rnd%0d_count", g), 32'(n), 32'(BEATS));
         check($sformatf("rnd%0d_drain", g), 32'(q.size()), 32'd0);
         fin = 1'b1;
      end
   end

   initial begin
      logic [15:0] bp_exp [4];
      logic [15:0] held;
      int          k, j;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      rst_r = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(in_ready), 32'd1);

      xfer("ror1", 16'h8001, 5'd1, 2'd0, 8'h11, 16'hC000);
      xfer("rol4", 16'h8001, 5'd4, 2'd1, 8'h22, 16'h0018);
      xfer("ror17", 16'h0003, 5'd17, 2'd0, 8'h33, 16'h8001);
      xfer("ror1b", 16'h0003, 5'd1, 2'd0, 8'h44, 16'h8001);
      xfer("asr20", 16'h8000, 5'd20, 2'd3, 8'h55, 16'hFFFF);
      xfer("shr20", 16'h8000, 5'd20, 2'd2, 8'h66, 16'h0000);
      xfer("asr3", 16'h4000, 5'd3, 2'd3, 8'h77, 16'h0800);

      for (int b = 0; b < 4; b++) bp_exp[b] = model(16'h1234 + 16'(b), 5'(b + 1), 2'd1);
      k = 0; j = 0; held = '0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         out_ready = n >= 5;
         in_valid  = k < 4;
         in_data   = 16'h1234 + 16'(k);
         in_dist   = 5'(k + 1);
         in_mode   = 2'd1;
         in_user   = 8'(k);
         #1;
         if (n == 2) begin
            check("bp_ready_drop", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            held = out_data;
         end
         if (n == 3 || n == 4) check("bp_stable", 32'(out_data), 32'(held));
         if (in_valid && in_ready) k++;
         if (out_valid && out_ready) begin
            check("bp_tag", 32'(out_user), 32'(j));
            check("bp_data", 32'(out_data), 32'(bp_exp[j % 4]));
            j++;
         end
      end
      in_valid = 1'b0;
      check("bp_count", 32'(j), 32'd4);

      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'hAAAA; in_dist = 5'd1; in_user = 8'hA0;
      @(negedge clk);
      in_data = 16'h5555; in_user = 8'hB0;
      @(posedge clk);
      #2 rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_ready", 32'(in_ready), 32'd0);
      check("async_rst_data", 32'({out_user, out_data}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_ready", 32'(in_ready), 32'd1);
      j = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (out_valid) j++;
      end
      check("rst_discard", 32'(j), 32'd0);

      go = 1'b1;
      for (int c = 0; c < 30000; c++) begin
         @(negedge clk);
         if (g_rnd[1].fin && g_rnd[2].fin && g_rnd[3].fin && g_rnd[4].fin && g_rnd[5].fin) break;
      end
      check("rnd_done", 32'({g_rnd[5].fin, g_rnd[4].fin, g_rnd[3].fin, g_rnd[2].fin, g_rnd[1].fin}),
            32'h1f);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
